// File: rtl/sha256_padder.sv
// sha256_padder
// Collects message bytes into a 64-byte buffer and emits 512-bit SHA-256
// blocks with the standard padding: a 0x80 marker, zero fill, and the
// 64-bit big-endian message bit-length in the last eight bytes. When the
// marker lands at byte 56 or later, an extra block carrying only zeros and
// the length follows.
//
// Ports
//   clock           rising-edge clock
//   reset           synchronous reset, active-low
//   load_enable     input_data holds a valid message byte this cycle
//   input_complete  single-cycle pulse marking the end of the message
//   input_data      message byte
//   in_ready        bytes and input_complete are accepted this cycle
//   block_valid     block_data holds a complete 512-bit block
//   block_data      block; byte 0 at [511:504], byte 63 at [7:0]
//   block_last      with block_valid: final padded block of the message
//   block_ready     downstream core takes the block this cycle
module sha256_padder (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_enable,
  input  logic         input_complete,
  input  logic [7:0]   input_data,
  output logic         in_ready,
  output logic         block_valid,
  output logic [511:0] block_data,
  output logic         block_last,
  input  logic         block_ready
);

  typedef enum logic [1:0] {LOAD, SEND, SEND_PAD, SEND_LAST} state_e;

  state_e      state_q;
  logic [5:0]  idx_q;
  logic [63:0] len_q;
  logic [7:0]  buf_q [64];
  logic        in_ready_q;
  logic        valid_q;
  logic        last_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= LOAD;
      idx_q      <= '0;
      len_q      <= '0;
      buf_q      <= '{default: 8'h00};
      in_ready_q <= 1'b1;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          // A byte takes priority over a simultaneous end-of-message pulse.
          if (load_enable) begin
            buf_q[idx_q] <= input_data;
            idx_q        <= idx_q + 6'd1;
            len_q        <= len_q + 64'd8;
            if (idx_q == 6'd63) begin
              state_q    <= SEND;
              in_ready_q <= 1'b0;
              valid_q    <= 1'b1;
              last_q     <= 1'b0;
            end
          end else if (input_complete) begin
            // Marker at idx, zeros above; bytes below idx keep the message.
            for (int i = 0; i < 64; i++) begin
              if (6'(i) == idx_q)
                buf_q[6'(i)] <= 8'h80;
              else if (6'(i) > idx_q)
                buf_q[6'(i)] <= 8'h00;
            end
            // Length fits in this block only if the marker left bytes
            // 56..63 free; these later assignments override the zero fill.
            if (idx_q <= 6'd55) begin
              for (int k = 0; k < 8; k++)
                buf_q[6'(56 + k)] <= len_q[63 - 8*k -: 8];
              state_q <= SEND_LAST;
              last_q  <= 1'b1;
            end else begin
              state_q <= SEND_PAD;
              last_q  <= 1'b0;
            end
            in_ready_q <= 1'b0;
            valid_q    <= 1'b1;
          end
        end

        SEND: begin
          if (block_ready) begin
            state_q    <= LOAD;
            in_ready_q <= 1'b1;
            valid_q    <= 1'b0;
          end
        end

        SEND_PAD: begin
          // Follow-on block: all zeros except the length.
          if (block_ready) begin
            for (int i = 0; i < 56; i++)
              buf_q[6'(i)] <= 8'h00;
            for (int k = 0; k < 8; k++)
              buf_q[6'(56 + k)] <= len_q[63 - 8*k -: 8];
            state_q <= SEND_LAST;
            last_q  <= 1'b1;
          end
        end

        SEND_LAST: begin
          if (block_ready) begin
            idx_q      <= '0;
            len_q      <= '0;
            buf_q      <= '{default: 8'h00};
            state_q    <= LOAD;
            in_ready_q <= 1'b1;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
          end
        end

        default: state_q <= LOAD;
      endcase
    end
  end

  // Output block is a pure rewiring of the buffer register.
  for (genvar g = 0; g < 64; g++) begin : g_pack
    assign block_data[511 - 8*g -: 8] = buf_q[g];
  end

  assign in_ready    = in_ready_q;
  assign block_valid = valid_q;
  assign block_last  = last_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Testbench for sha256_padder: directed messages plus randomized messages,
// expected blocks queued by a reference padding model and checked by an
// independent monitor that also drives block_ready.
module tb_sha256_padder;

  typedef logic [7:0] u8;
  typedef struct packed {
    logic [511:0] data;
    logic         last;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         load_enable = 1'b0;
  logic         input_complete = 1'b0;
  logic [7:0]   input_data = 8'h00;
  logic         in_ready;
  logic         block_valid;
  logic [511:0] block_data;
  logic         block_last;
  logic         block_ready = 1'b0;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   ready_mode = 2;   // 0 random, 1 hold low, 2 always high
  bit   gaps = 1'b0;

  sha256_padder dut (
    .clock          (clock),
    .reset          (reset),
    .load_enable    (load_enable),
    .input_complete (input_complete),
    .input_data     (input_data),
    .in_ready       (in_ready),
    .block_valid    (block_valid),
    .block_data     (block_data),
    .block_last     (block_last),
    .block_ready    (block_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Reference: standard SHA-256 message padding split into 64-byte blocks.
  function automatic void push_model(input u8 m[$]);
    u8           p[$];
    logic [63:0] bl;
    exp_t        e;
    int          nb;
    p  = m;
    bl = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      e.data = '0;
      for (int j = 0; j < 64; j++) e.data[511 - 8*j -: 8] = p[64*b + j];
      e.last = (b == nb - 1);
      sb.push_back(e);
    end
  endfunction

  // Monitor: chooses block_ready, checks stability and scoreboard order.
  logic [511:0] held_data;
  logic         held_last;
  bit           held = 1'b0;
  always @(negedge clock) begin
    bit   r;
    exp_t e;
    if (!reset) begin
      block_ready = 1'b0;
      held = 1'b0;
    end else begin
      if (held && block_valid) begin
        chk("stable_data", block_data, held_data);
        chk("stable_last", 512'(block_last), 512'(held_last));
      end
      r = (ready_mode == 0) ? ($urandom % 3 != 0) : (ready_mode == 2);
      block_ready = r;
      if (block_valid && r) begin
        held = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_block: got %0h required none", block_data);
        end else begin
          e = sb.pop_front();
          chk("block_data", block_data, e.data);
          chk("block_last", 512'(block_last), 512'(e.last));
        end
      end else if (block_valid) begin
        held = 1'b1;
        held_data = block_data;
        held_last = block_last;
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic drive_idle();
    load_enable = 1'b0;
    input_complete = 1'b0;
    input_data = 8'($urandom);
  endtask

  // Change ready policy just after a rising edge so the monitor applies it
  // from the following falling edge.
  task automatic set_mode(input int m);
    @(posedge clock);
    #1;
    ready_mode = m;
    drive_idle();
  endtask

  // Wait for in_ready while offering junk that must be dropped.
  task automatic wait_ready();
    int n = 0;
    @(negedge clock);
    while (!in_ready && n < 3000) begin
      load_enable = 1'($urandom % 2);
      input_complete = 1'($urandom % 2);
      input_data = 8'($urandom);
      n++;
      @(negedge clock);
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout: got 0 required 1");
    end
  endtask

  task automatic send_byte(input u8 b, input bit cplt);
    wait_ready();
    load_enable = 1'b1;
    input_data = b;
    input_complete = cplt;
  endtask

  task automatic send_complete();
    wait_ready();
    load_enable = 1'b0;
    input_complete = 1'b1;
    input_data = 8'($urandom);
  endtask

  task automatic finish_msg(input int n);
    send_complete();
    @(negedge clock);
    drive_idle();
    chk("valid_after_complete", 512'(block_valid), 512'(1'b1));
    chk("last_after_complete", 512'(block_last), 512'((n % 64) <= 55));
    chk("in_ready_while_sending", 512'(in_ready), 512'(1'b0));
  endtask

  task automatic send_msg(input u8 m[$], input bit model);
    if (model) push_model(m);
    for (int i = 0; i < m.size(); i++) begin
      send_byte(m[i], 1'($urandom % 6 == 0));
      if ((i + 1) % 64 == 0) begin
        @(negedge clock);
        drive_idle();
        chk("valid_after_64th", 512'(block_valid), 512'(1'b1));
        chk("last_after_64th", 512'(block_last), 512'(1'b0));
      end else if (gaps && ($urandom % 4 == 0)) begin
        @(negedge clock);
        drive_idle();
      end
    end
    finish_msg(m.size());
  endtask

  function automatic void rand_msg(output u8 m[$], input int n);
    m = {};
    for (int i = 0; i < n; i++) m.push_back(8'($urandom));
  endfunction

  initial begin
    u8    m[$];
    exp_t e;
    int   n;

    // Reset state
    repeat (2) @(negedge clock);
    chk("reset_in_ready", 512'(in_ready), 512'(1'b1));
    chk("reset_valid", 512'(block_valid), 512'(1'b0));
    chk("reset_last", 512'(block_last), 512'(1'b0));
    chk("reset_data", block_data, 512'h0);
    reset = 1'b1;

    // Empty message
    e.data = {8'h80, 504'h0};
    e.last = 1'b1;
    sb.push_back(e);
    m = {};
    send_msg(m, 1'b0);

    // "abc"
    e.data = {32'h61626380, 416'h0, 64'h18};
    e.last = 1'b1;
    sb.push_back(e);
    m = {8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0);

    // "goirish\n"
    m = {8'h67, 8'h6f, 8'h69, 8'h72, 8'h69, 8'h73, 8'h68, 8'h0a};
    send_msg(m, 1'b1);

    // Padding boundaries
    rand_msg(m, 55); send_msg(m, 1'b1);
    rand_msg(m, 56); send_msg(m, 1'b1);
    rand_msg(m, 63); send_msg(m, 1'b1);
    rand_msg(m, 64); send_msg(m, 1'b1);

    // Backpressure on a full block
    set_mode(1);
    rand_msg(m, 64);
    push_model(m);
    for (int i = 0; i < 64; i++) send_byte(m[i], 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      load_enable = 1'b1;
      input_complete = 1'($urandom % 2);
      input_data = 8'($urandom);
      chk("bp_in_ready", 512'(in_ready), 512'(1'b0));
      chk("bp_valid", 512'(block_valid), 512'(1'b1));
    end
    set_mode(2);
    @(negedge clock);
    drive_idle();
    @(negedge clock);
    drive_idle();
    chk("bp_release_in_ready", 512'(in_ready), 512'(1'b1));
    finish_msg(64);

    // Reset while the extra padding block is pending
    set_mode(1);
    rand_msg(m, 60);
    send_msg(m, 1'b1);
    @(negedge clock);
    drive_idle();
    reset = 1'b0;
    sb.delete();
    @(negedge clock);
    chk("abort_valid", 512'(block_valid), 512'(1'b0));
    chk("abort_in_ready", 512'(in_ready), 512'(1'b1));
    reset = 1'b1;
    set_mode(2);
    e.data = {32'h61626380, 416'h0, 64'h18};
    e.last = 1'b1;
    sb.push_back(e);
    m = {8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0);

    // Randomized messages with random gaps and backpressure
    set_mode(0);
    gaps = 1'b1;
    for (int t = 0; t < 30; t++) begin
      n = $urandom_range(0, 150);
      rand_msg(m, n);
      send_msg(m, 1'b1);
    end

    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clock);
      drive_idle();
      n++;
    end
    chk("drain", 512'(sb.size()), 512'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
